seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Iterative restoring divider; the inverse of the team's sequential shift-add multiplier.
- Takes a signed 2*WIDTH-bit dividend (a multiplier product) and a signed WIDTH-bit divisor.
- Returns a signed quotient and remainder after one bit-iteration per cycle.
- Uses the same Start/Done handshake as the multiplier, so the two share a control sequencer in the arithmetic unit.

Parameters:
- WIDTH, 8, divisor and remainder width. Dividend and quotient are 2*WIDTH bits.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- Start  in  1  request; sampled only in IDLE.
- Dividend  in  2*WIDTH  signed two's complement; captured on accepted Start.
- Divisor  in  WIDTH  signed two's complement; captured on accepted Start.
- Quotient  out  2*WIDTH  signed result, truncated toward zero.
- Remainder  out  WIDTH  signed; sign follows dividend; |Remainder| < |Divisor|.
- Busy  out  1  high from LOAD through FIX.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; Quotient=0, Remainder=0, Busy=0, Done=0; all internal registers cleared.
  - Reset mid-operation aborts; no Done is produced.
- States: IDLE, LOAD, CALC, FIX.
- IDLE:
  - Start=1 at a rising edge captures Dividend and Divisor and moves to LOAD.
  - Start=0 stays in IDLE.
  - Start is ignored in every other state; inputs may change freely while Busy=1.
- LOAD (1 cycle):
  - Forms unsigned magnitudes (2*WIDTH-bit dividend, WIDTH-bit divisor) and records both signs.
  - Clears the partial remainder, iteration counter = 2*WIDTH.
  - If Divisor=0, go straight to FIX with the divide-by-zero path; else go to CALC.
- CALC (2*WIDTH cycles, MSB first), per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial subtract the divisor magnitude; if it is non-negative, keep the difference and set quotient bit 1, else restore and set quotient bit 0.
  - Decrement the counter; when the counter reaches 1 at the edge, go to FIX.
  - The partial remainder is WIDTH+1 bits to hold the shifted value.
- FIX (1 cycle):
  - Quotient is negated if the signs differ.
  - Remainder is negated if the dividend is negative.
  - Registers Quotient, Remainder; sets Done=1 for exactly one cycle; returns to IDLE.
- Latency:
  - Start sampled at edge 0; Done is high for the cycle following edge 2*WIDTH+2, i.e. 18 cycles for WIDTH=8.
  - Divide by zero: Done after edge 2.
- Outputs hold their values until the FIX of the next operation; they are not cleared on Start.
- Busy=1 from the edge entering LOAD until the edge leaving FIX.
- While Done=1 the FSM is in IDLE, so a Start in that same cycle is accepted; back-to-back operation is legal.
- Divide by zero: Quotient = all ones (-1), Remainder = Dividend[WIDTH-1:0].
- Overflow: only the most-negative dividend divided by -1. Quotient wraps to the most-negative value (-32768 for WIDTH=8), Remainder=0.
- Magnitude of the most-negative dividend (32768) is representable as unsigned 2*WIDTH; no special casing is needed in CALC.

Optional Feature:
- Macro: SEQ_DIV_ERROR_FLAG_EN.
- When defined: adds output port Error (1 bit), registered together with Done.
  - Error=1 on divide-by-zero or on overflow; otherwise 0.
  - Error holds with the results until the next FIX; it resets to 0.
- When undefined: no Error port. Result values in both error cases are exactly as specified above.

Test Plan:
- Reset low 20 ns then high; Dividend=120, Divisor=12, pulse Start -> Done after 18 cycles; Quotient=10, Remainder=0; Busy low after Done.
- Dividend=-5, Divisor=3 -> Quotient=-1, Remainder=-2. Dividend=1000, Divisor=-7 -> Quotient=-142, Remainder=6. Dividend=-1000, Divisor=-7 -> Quotient=142, Remainder=-6.
- Dividend=500, Divisor=0 -> Done after 2 cycles; Quotient=16'hFFFF, Remainder=8'hF4; Error=1 if enabled.
- Dividend=-32768, Divisor=-1 -> Quotient=-32768, Remainder=0; Error=1 if enabled. Dividend=32767, Divisor=-128 -> Quotient=-255, Remainder=127; Error=0.
- Start 120/12; re-pulse Start with 50/5 at cycle 5 -> ignored; result 10 r0. Start 50/5 in the Done cycle -> accepted; Quotient=10, Remainder=0 after 18 more cycles.
- Start 255/3; drive Reset low at cycle 7 -> all outputs 0 immediately, no Done. Release Reset, run 255/3 -> Quotient=85, Remainder=0.

Source files
------------

// File: rtl/seq_signed_divider.sv
// ---------------------------------------------------------------------------
// seq_signed_divider
//
// Iterative restoring divider. Divides a signed 2*WIDTH-bit dividend by a
// signed WIDTH-bit divisor, one quotient bit per clock, and shares the
// start/done handshake of the sequential shift-add multiplier.
// Quotient truncates toward zero. The remainder takes the sign of the
// dividend, and its magnitude is less than the divisor's.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        request, sampled only while idle
//   dividend   in   2*WIDTH  signed dividend, captured on accepted start
//   divisor    in   WIDTH    signed divisor, captured on accepted start
//   quotient   out  2*WIDTH  signed quotient (held until next completion)
//   remainder  out  WIDTH    signed remainder (held until next completion)
//   busy       out  1        high from LOAD through FIX
//   done       out  1        one-cycle completion pulse
//   error      out  1        only with SEQ_DIV_ERROR_FLAG_EN defined:
//                            divide-by-zero or overflow, held with results
//
// Optional feature macro: SEQ_DIV_ERROR_FLAG_EN
// ---------------------------------------------------------------------------
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done
`ifdef SEQ_DIV_ERROR_FLAG_EN
    ,
    output logic                 error
`endif
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    // dvd holds the raw dividend, then its magnitude, and finally collects
    // the quotient bits as they are shifted in from the bottom.
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]  rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dvd_neg_q, dvd_neg_d;
    logic            dvs_neg_q, dvs_neg_d;
    logic            div0_q, div0_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic            done_q, done_d;
`ifdef SEQ_DIV_ERROR_FLAG_EN
    logic            error_q, error_d;
`endif

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             sign_diff;

    // The partial remainder never exceeds the divisor magnitude, so the
    // shifted value fits in WIDTH+1 bits and the top bit of the WIDTH+2-bit
    // trial difference is a clean borrow flag.
    assign shifted   = {1'b0, rem_q, dvd_q[DW-1]};
    assign trial     = shifted - {2'b00, dvs_q};
    assign sign_diff = dvd_neg_q ^ dvs_neg_q;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        div0_d      = div0_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
`ifdef SEQ_DIV_ERROR_FLAG_EN
        error_d     = error_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                dvd_neg_d = dvd_q[DW-1];
                dvs_neg_d = dvs_q[WIDTH-1];
                rem_d     = '0;
                cnt_d     = CW'(DW);
                if (dvs_q == '0) begin
                    // The raw dividend is kept: its low bits become the
                    // remainder on the divide-by-zero path.
                    div0_d  = 1'b1;
                    state_d = FIX;
                end else begin
                    // Negating the most-negative dividend yields its exact
                    // unsigned magnitude, so CALC needs no special case.
                    div0_d  = 1'b0;
                    dvd_d   = dvd_q[DW-1] ? -dvd_q : dvd_q;
                    dvs_d   = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                    state_d = CALC;
                end
            end

            CALC: begin
                if (trial[WIDTH+1]) begin
                    rem_d = shifted[WIDTH:0];
                    dvd_d = {dvd_q[DW-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH:0];
                    dvd_d = {dvd_q[DW-2:0], 1'b1};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (div0_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q[WIDTH-1:0];
`ifdef SEQ_DIV_ERROR_FLAG_EN
                    error_d     = 1'b1;
`endif
                end else begin
                    // Negating a 2^(DW-1) magnitude wraps back to the
                    // most-negative value, which is the required overflow
                    // result for most-negative / -1.
                    quotient_d  = sign_diff ? -dvd_q : dvd_q;
                    remainder_d = dvd_neg_q ? -rem_q[WIDTH-1:0]
                                            : rem_q[WIDTH-1:0];
`ifdef SEQ_DIV_ERROR_FLAG_EN
                    // A positive quotient with the top magnitude bit set
                    // cannot be represented; only most-negative / -1 does it.
                    error_d     = ~sign_diff & dvd_q[DW-1];
`endif
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the held results, clears asynchronously so that
    // an abort mid-operation leaves nothing behind and never raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            div0_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
`ifdef SEQ_DIV_ERROR_FLAG_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            div0_q      <= div0_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
`ifdef SEQ_DIV_ERROR_FLAG_EN
            error_q     <= error_d;
`endif
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
`ifdef SEQ_DIV_ERROR_FLAG_EN
    assign error     = error_q;
`endif

endmodule

// File: tb/tb_seq_signed_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_signed_divider
//
// Directed bench for seq_signed_divider with WIDTH=8. Expected quotients,
// remainders and latencies are worked out by hand for each vector.
// Build with SEQ_DIV_ERROR_FLAG_EN defined to also check the error flag.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_signed_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
`ifdef SEQ_DIV_ERROR_FLAG_EN
    logic        error;
`endif

    int checks = 0;
    int errors = 0;
    int n      = 0;
    logic sawDone;

    seq_signed_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_DIV_ERROR_FLAG_EN
        ,
        .error     (error)
`endif
    );

    // 10 ns clock; posedges at 5, 15, 25, ... and all sampling on negedges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: bump the check count, flag and count any mismatch.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present operands with start for exactly one rising edge. Afterwards we
    // sit at the negedge following the accepting edge, which is cycle n=0.
    task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        n        = 0;
    endtask

    // Advance negedge by negedge until cycle n reaches target.
    task automatic stepTo(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Wait (bounded) for done and check on which cycle it appeared.
    task automatic waitDone(input string tag, input int expLat);
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(n), 16'(expLat));
    endtask

    // Full operation: start, busy in LOAD, latency, results, then idle.
    task automatic runCase(input string tag, input logic [15:0] dvd,
                           input logic [7:0] dvs, input logic [15:0] qExp,
                           input logic [7:0] rExp, input int latExp,
                           input logic errExp);
        applyStimulus(dvd, dvs);
        checkOutput({tag, "_busy"}, {15'b0, busy}, 16'h0001);
        waitDone({tag, "_lat"}, latExp);
        checkOutput({tag, "_q"}, quotient, qExp);
        checkOutput({tag, "_r"}, {8'b0, remainder}, {8'b0, rExp});
`ifdef SEQ_DIV_ERROR_FLAG_EN
        checkOutput({tag, "_err"}, {15'b0, error}, {15'b0, errExp});
`else
        if (errExp === 1'bx) $display("[TB] unexpected error expectation");
`endif
        @(negedge clk);
        n++;
        checkOutput({tag, "_doneoff"}, {15'b0, done}, 16'h0000);
        checkOutput({tag, "_idle"}, {15'b0, busy}, 16'h0000);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state while rst_n is held low.
        #12;
        checkOutput("rst_q", quotient, 16'h0000);
        checkOutput("rst_r", {8'b0, remainder}, 16'h0000);
        checkOutput("rst_busy", {15'b0, busy}, 16'h0000);
        checkOutput("rst_done", {15'b0, done}, 16'h0000);
        #8;
        rst_n = 1'b1;

        // Basic and signed cases.
        runCase("p120_12", 16'd120, 8'd12, 16'd10, 8'd0, 18, 1'b0);
        runCase("m5_3", -16'sd5, 8'd3, -16'sd1, -8'sd2, 18, 1'b0);
        runCase("p1000_m7", 16'd1000, -8'sd7, -16'sd142, 8'd6, 18, 1'b0);
        runCase("m1000_m7", -16'sd1000, -8'sd7, 16'd142, -8'sd6, 18, 1'b0);

        // Divide by zero: short path, all-ones quotient, low dividend bits.
        runCase("div0", 16'd500, 8'd0, 16'hFFFF, 8'hF4, 2, 1'b1);

        // Overflow and extreme magnitudes.
        runCase("ovf", 16'h8000, 8'hFF, 16'h8000, 8'd0, 18, 1'b1);
        runCase("p32767_m128", 16'd32767, 8'h80, -16'sd255, 8'd127, 18, 1'b0);

        // Outputs hold across a new start; a second start while busy is ignored.
        applyStimulus(16'd120, 8'd12);
        stepTo(5);
        checkOutput("hold_q", quotient, -16'sd255);
        checkOutput("hold_r", {8'b0, remainder}, 16'd127);
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        n++;
        start    = 1'b0;
        dividend = 16'd7;
        divisor  = 8'd2;
        waitDone("ign_lat", 18);
        checkOutput("ign_q", quotient, 16'd10);
        checkOutput("ign_r", {8'b0, remainder}, 16'd0);

        // Back-to-back: start accepted in the done cycle.
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        n        = 0;
        checkOutput("b2b_busy", {15'b0, busy}, 16'h0001);
        waitDone("b2b_lat", 18);
        checkOutput("b2b_q", quotient, 16'd10);
        checkOutput("b2b_r", {8'b0, remainder}, 16'd0);

        // Reset mid-operation aborts immediately and produces no done.
        applyStimulus(16'd255, 8'd3);
        stepTo(7);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_q", quotient, 16'h0000);
        checkOutput("abort_busy", {15'b0, busy}, 16'h0000);
        checkOutput("abort_done", {15'b0, done}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            sawDone = sawDone | done;
        end
        checkOutput("abort_nodone", {15'b0, sawDone}, 16'h0000);
        checkOutput("abort_idle", {15'b0, busy}, 16'h0000);
        runCase("p255_3", 16'd255, 8'd3, 16'd85, 8'd0, 18, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
